// File: rtl/hawk_walk_timer_pkg.sv
// ----------------------------------------------------------------------------
// hawk_walk_timer_pkg
// Shared definitions for the HAWK walk-interval timer and the HAWK sequencing
// FSM: timer state encodings, default timing parameters and the binary-to-BCD
// helper used by the countdown display path.
// Ports: none (package).
// ----------------------------------------------------------------------------
package hawk_walk_timer_pkg;

  // Default timing: 100 MHz clock, 15 s walk interval.
  localparam int DEF_TICK_DIV  = 100_000_000;
  localparam int DEF_WALK_SECS = 15;

  // Encodings are shared with the sequencing FSM; keep them fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

  // Binary 0..63 to two BCD digits {tens, ones} by repeated compare/subtract.
  // Six passes are enough because 63 needs at most six subtractions of 10.
  function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
    logic [5:0] rem;
    logic [3:0] tens;
    rem  = v;
    tens = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end else begin
        rem  = rem;
      end
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/hawk_walk_timer_tick.sv
// ----------------------------------------------------------------------------
// hawk_tick_prescaler
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-low reset
//   en    in  count enable; counter holds when low
//   clr   in  synchronous clear of the counter
//   tick  out high in the enabled cycle where the counter sits at TICK_DIV-1
// ----------------------------------------------------------------------------
module hawk_tick_prescaler
  import hawk_walk_timer_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Next-count and tick decode.
  always_comb begin
    cnt_d = cnt_q;
    tick  = en && (cnt_q == LAST);
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + {{(PW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hawk_walk_timer.sv
// ----------------------------------------------------------------------------
// hawk_walk_timer
// Walk-interval timer beside the HAWK sequencing FSM. Runs while inc_count is
// high, pauses while it is low, and raises count once WALK_SECS seconds of
// run time have elapsed. count is held until clr_count. Also provides the
// seconds remaining for the pedestrian countdown display.
// Optional feature macro: HAWK_COUNTDOWN_BCD_EN (registered BCD digits of
// secs_left on bcd_tens / bcd_ones; when undefined both are constant 0).
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   clr_count  in  synchronous clear (highest priority)
//   inc_count  in  run/advance while high
//   count      out walk interval elapsed (registered, sticky until clear)
//   tick       out one-cycle pulse on each counted second
//   secs_left  out WALK_SECS minus elapsed seconds (registered)
//   bcd_tens   out tens digit of secs_left
//   bcd_ones   out ones digit of secs_left
// ----------------------------------------------------------------------------
module hawk_walk_timer
  import hawk_walk_timer_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int WALK_SECS = DEF_WALK_SECS,
  parameter int SEC_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_count,
  input  logic             inc_count,
  output logic             count,
  output logic             tick,
  output logic [SEC_W-1:0] secs_left,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  generate
    if (WALK_SECS < 1 || WALK_SECS > 63) begin : g_bad_walk_secs
      $error("hawk_walk_timer: WALK_SECS must be 1..63");
    end
    if (TICK_DIV < 2) begin : g_bad_tick_div
      $error("hawk_walk_timer: TICK_DIV must be >= 2");
    end
    if (SEC_W < 6) begin : g_bad_sec_w
      $error("hawk_walk_timer: SEC_W must be >= 6");
    end
  endgenerate

  localparam logic [SEC_W-1:0] WS      = SEC_W'(WALK_SECS);
  localparam logic [SEC_W-1:0] WS_LAST = SEC_W'(WALK_SECS - 1);

  timer_state_e     state_q, state_d;
  logic [SEC_W-1:0] elapsed_q, elapsed_d;
  logic [SEC_W-1:0] secs_left_q, secs_left_d;
  logic             count_q, count_d;
  logic             presc_en_s;
  logic             tick_s;

  // Prescaler only advances while running and not being cleared; frozen in DONE.
  assign presc_en_s = inc_count && !clr_count && (state_q != ST_DONE);

  hawk_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (presc_en_s),
    .clr   (clr_count),
    .tick  (tick_s)
  );

  assign tick = tick_s;

  // Next-state and elapsed-seconds logic; clear beats everything.
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    count_d   = count_q;
    if (clr_count) begin
      state_d   = ST_IDLE;
      elapsed_d = '0;
      count_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (inc_count) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (tick_s) begin
            if (elapsed_q == WS_LAST) begin
              elapsed_d = WS;
              state_d   = ST_DONE;
              count_d   = 1'b1;
            end else begin
              elapsed_d = elapsed_q + {{(SEC_W-1){1'b0}}, 1'b1};
            end
          end else begin
            elapsed_d = elapsed_q;
          end
        end
        ST_DONE: begin
          count_d = 1'b1;
        end
        default: begin
          state_d   = ST_IDLE;
          elapsed_d = '0;
          count_d   = 1'b0;
        end
      endcase
    end
    // elapsed never exceeds WALK_SECS, so this cannot underflow.
    secs_left_d = WS - elapsed_d;
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      elapsed_q   <= '0;
      count_q     <= 1'b0;
      secs_left_q <= WS;
    end else begin
      state_q     <= state_d;
      elapsed_q   <= elapsed_d;
      count_q     <= count_d;
      secs_left_q <= secs_left_d;
    end
  end

  assign count     = count_q;
  assign secs_left = secs_left_q;

`ifdef HAWK_COUNTDOWN_BCD_EN
  localparam logic [7:0] WS_BCD = bin_to_bcd(6'(WALK_SECS));

  logic [3:0] bcd_tens_q, bcd_ones_q;
  logic [7:0] bcd_d;

  // Convert the next secs_left so digits update on the same edge.
  always_comb begin
    bcd_d = bin_to_bcd(secs_left_d[5:0]);
  end

  // BCD digit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_tens_q <= WS_BCD[7:4];
      bcd_ones_q <= WS_BCD[3:0];
    end else begin
      bcd_tens_q <= bcd_d[7:4];
      bcd_ones_q <= bcd_d[3:0];
    end
  end

  assign bcd_tens = bcd_tens_q;
  assign bcd_ones = bcd_ones_q;
`else
  assign bcd_tens = 4'h0;
  assign bcd_ones = 4'h0;
`endif

endmodule
